// File: rtl/ahbl_gpio_bank.sv
// ahbl_gpio_bank: zero-wait-state AHB-Lite GPIO bank with synchronised
// inputs, per-bit rising-edge interrupt status (RW1C) and a registered
// per-port interrupt level on user_irq.
module ahbl_gpio_bank #(
    parameter int NPORTS      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                HSEL,
    input  logic [31:0]         HADDR,
    input  logic [31:0]         HWDATA,
    input  logic                HREADY,
    input  logic                HWRITE,
    input  logic [1:0]          HTRANS,
    input  logic [2:0]          HSIZE,
    output logic [31:0]         HRDATA,
    output logic                HREADYOUT,
    input  logic [8*NPORTS-1:0] gpio_in,
    output logic [8*NPORTS-1:0] gpio_out,
    output logic [8*NPORTS-1:0] gpio_oeb,
    output logic [15:0]         user_irq
);
    localparam int W = 8 * NPORTS;

    // Address-phase capture (drives the data phase)
    logic       ph_valid_q, ph_valid_d;
    logic [7:0] ph_addr_q, ph_addr_d;
    logic       ph_write_q, ph_write_d;
    logic       ph_word_q, ph_word_d;

    // Write committed one cycle after its data phase
    logic       wr_valid_q, wr_valid_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;

    // Input synchroniser chain and one-cycle-delayed copy for edge detection
    logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
    logic [W-1:0]                  prev_q, prev_d;
    logic [W-1:0]                  sync_w;
    logic [W-1:0]                  edge_w;

    // Per-port read values, padded to eight slots so the read mux needs no range check
    logic [7:0] port_rd [8];
    logic [7:0] stat_rd [8];
    logic [7:0] irq_bits;

    logic unused_sig;

    assign HREADYOUT  = 1'b1;
    assign sync_w     = sync_q[SYNC_STAGES-1];
    assign edge_w     = sync_w & ~prev_q;
    assign user_irq   = {8'h00, irq_bits};
    assign unused_sig = &{1'b0, HADDR[31:8], HWDATA[31:8], HTRANS[0],
                          ph_addr_q[1:0], wr_addr_q[1:0]};

    // Next state of the bus pipeline and input synchroniser
    always_comb begin
        ph_valid_d = HSEL & HREADY & HTRANS[1];
        ph_addr_d  = ph_addr_q;
        ph_write_d = ph_write_q;
        ph_word_d  = ph_word_q;
        if (ph_valid_d) begin
            ph_addr_d  = HADDR[7:0];
            ph_write_d = HWRITE;
            ph_word_d  = (HSIZE == 3'b010);
        end
        // Sub-word writes are dropped here so they never reach a register
        wr_valid_d = ph_valid_q & ph_write_q & ph_word_q;
        wr_addr_d  = ph_addr_q;
        wr_data_d  = HWDATA[7:0];
        sync_d     = {sync_q[SYNC_STAGES-2:0], gpio_in};
        prev_d     = sync_w;
    end

    // Bus pipeline and synchroniser flops
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ph_valid_q <= 1'b0;
            ph_addr_q  <= 8'h00;
            ph_write_q <= 1'b0;
            ph_word_q  <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
            sync_q     <= '0;
            prev_q     <= '0;
        end else begin
            ph_valid_q <= ph_valid_d;
            ph_addr_q  <= ph_addr_d;
            ph_write_q <= ph_write_d;
            ph_word_q  <= ph_word_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_port
            if (gi < NPORTS) begin : g_live
                logic [7:0] out_q, out_d;
                logic [7:0] oeb_q, oeb_d;
                logic [7:0] ie_q, ie_d;
                logic [7:0] stat_q, stat_d;
                logic       irq_q, irq_d;
                logic [7:0] in_v, edge_v, w1c_v, rd_v;
                logic       port_hit, stat_hit;

                assign in_v     = sync_w[8*gi +: 8];
                assign edge_v   = edge_w[8*gi +: 8];
                assign port_hit = wr_valid_q && !wr_addr_q[7] && (wr_addr_q[6:4] == 3'(gi));
                assign stat_hit = wr_valid_q && (wr_addr_q[7:5] == 3'b100)
                                  && (wr_addr_q[4:2] == 3'(gi));

                // Register writes; status set has priority over a same-cycle W1C
                always_comb begin
                    out_d = out_q;
                    oeb_d = oeb_q;
                    ie_d  = ie_q;
                    if (port_hit) begin
                        case (wr_addr_q[3:2])
                            2'd1:    out_d = wr_data_q;
                            2'd2:    oeb_d = wr_data_q;
                            2'd3:    ie_d  = wr_data_q;
                            default: ;
                        endcase
                    end
                    w1c_v  = stat_hit ? wr_data_q : 8'h00;
                    stat_d = (stat_q & ~w1c_v) | (edge_v & ie_q);
                    irq_d  = |stat_q;
                end

                // Port register flops
                always_ff @(posedge HCLK or negedge HRESETn) begin
                    if (!HRESETn) begin
                        out_q  <= 8'h00;
                        oeb_q  <= 8'hFF;
                        ie_q   <= 8'h00;
                        stat_q <= 8'h00;
                        irq_q  <= 1'b0;
                    end else begin
                        out_q  <= out_d;
                        oeb_q  <= oeb_d;
                        ie_q   <= ie_d;
                        stat_q <= stat_d;
                        irq_q  <= irq_d;
                    end
                end

                // Read view of this port for the current data-phase address
                always_comb begin
                    case (ph_addr_q[3:2])
                        2'd0:    rd_v = in_v;
                        2'd1:    rd_v = out_q;
                        2'd2:    rd_v = oeb_q;
                        default: rd_v = ie_q;
                    endcase
                end

                assign port_rd[gi]          = rd_v;
                assign stat_rd[gi]          = stat_q;
                assign irq_bits[gi]         = irq_q;
                assign gpio_out[8*gi +: 8]  = out_q;
                assign gpio_oeb[8*gi +: 8]  = oeb_q;
            end else begin : g_absent
                assign port_rd[gi]  = 8'h00;
                assign stat_rd[gi]  = 8'h00;
                assign irq_bits[gi] = 1'b0;
            end
        end
    endgenerate

    // Read data decoded from the captured address; zero outside read data phases
    always_comb begin
        HRDATA = 32'd0;
        if (ph_valid_q && !ph_write_q) begin
            if (!ph_addr_q[7]) begin
                HRDATA[7:0] = port_rd[ph_addr_q[6:4]];
            end else if (ph_addr_q[6:5] == 2'b00) begin
                HRDATA[7:0] = stat_rd[ph_addr_q[4:2]];
            end
        end
    end

endmodule

// File: tb/tb_ahbl_gpio_bank.sv
// Testbench for ahbl_gpio_bank: directed AHB transfers, a cycle model of the
// register map, and per-cycle comparison of all outputs against the model.
module tb_ahbl_gpio_bank;
    localparam int NP   = 8;
    localparam int SYNC = 2;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b1;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = 32'd0;
    logic [31:0] HWDATA = 32'd0;
    logic        HREADY = 1'b1;
    logic        HWRITE = 1'b0;
    logic [1:0]  HTRANS = 2'b00;
    logic [2:0]  HSIZE = 3'b010;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [63:0] gpio_in = 64'd0;
    logic [63:0] gpio_out;
    logic [63:0] gpio_oeb;
    logic [15:0] user_irq;

    int tests = 0;
    int fails = 0;

    always #5 HCLK = ~HCLK;

    ahbl_gpio_bank #(.NPORTS(NP), .SYNC_STAGES(SYNC)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HWDATA(HWDATA), .HREADY(HREADY), .HWRITE(HWRITE), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oeb(gpio_oeb),
        .user_irq(user_irq)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_out [NP];
    logic [7:0]  m_oeb [NP];
    logic [7:0]  m_ie  [NP];
    logic [7:0]  m_stat[NP];
    logic [7:0]  m_clr [NP];
    logic [NP-1:0] m_irq;
    logic [63:0] m_pad [SYNC+1];   // pad samples by age: [0] = newest edge
    logic [63:0] m_rise;
    logic        m_ph_valid, m_ph_write, m_ph_word;
    logic [7:0]  m_ph_addr;
    logic        m_wr_valid;
    logic [7:0]  m_wr_addr, m_wr_data;
    int          m_a, m_p;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int p = 0; p < NP; p++) begin
                m_out[p] = 8'h00; m_oeb[p] = 8'hFF; m_ie[p] = 8'h00; m_stat[p] = 8'h00;
            end
            for (int k = 0; k <= SYNC; k++) m_pad[k] = 64'd0;
            m_irq = '0;
            m_ph_valid = 1'b0; m_ph_write = 1'b0; m_ph_word = 1'b0; m_ph_addr = 8'h00;
            m_wr_valid = 1'b0; m_wr_addr = 8'h00; m_wr_data = 8'h00;
        end else begin
            for (int p = 0; p < NP; p++) m_clr[p] = 8'h00;
            m_a = int'(m_wr_addr);
            if (m_wr_valid && m_a >= 'h80 && m_a < 'h80 + 4*NP)
                m_clr[(m_a - 'h80) / 4] = m_wr_data;
            // rising edge on the value that became visible one cycle ago
            m_rise = m_pad[SYNC-1] & ~m_pad[SYNC];
            for (int p = 0; p < NP; p++) begin
                m_irq[p]  = |m_stat[p];
                m_stat[p] = (m_stat[p] & ~m_clr[p]) | (m_rise[8*p +: 8] & m_ie[p]);
            end
            if (m_wr_valid && m_a < 'h80) begin
                m_p = m_a / 16;
                if (m_p < NP) begin
                    case ((m_a % 16) / 4)
                        1: m_out[m_p] = m_wr_data;
                        2: m_oeb[m_p] = m_wr_data;
                        3: m_ie[m_p]  = m_wr_data;
                        default: ;
                    endcase
                end
            end
            m_wr_valid = m_ph_valid && m_ph_write && m_ph_word;
            m_wr_addr  = m_ph_addr;
            m_wr_data  = HWDATA[7:0];
            m_ph_valid = HSEL && HREADY && HTRANS[1];
            if (m_ph_valid) begin
                m_ph_addr  = HADDR[7:0];
                m_ph_write = HWRITE;
                m_ph_word  = (HSIZE == 3'b010);
            end
            for (int k = SYNC; k > 0; k--) m_pad[k] = m_pad[k-1];
            m_pad[0] = gpio_in;
        end
    end

    function automatic logic [31:0] m_read(input logic [7:0] a);
        int ai = int'(a);
        int p;
        logic [63:0] inv = m_pad[SYNC-1];
        if (ai < 'h80) begin
            p = ai / 16;
            if (p >= NP) return 32'd0;
            case ((ai % 16) / 4)
                0: return {24'd0, inv[8*p +: 8]};
                1: return {24'd0, m_out[p]};
                2: return {24'd0, m_oeb[p]};
                default: return {24'd0, m_ie[p]};
            endcase
        end
        if (ai < 'h80 + 4*NP) return {24'd0, m_stat[(ai - 'h80) / 4]};
        return 32'd0;
    endfunction

    // Every-cycle comparison of outputs against the model
    always @(negedge HCLK) begin
        logic [63:0] eo, ee;
        for (int p = 0; p < NP; p++) begin
            eo[8*p +: 8] = m_out[p];
            ee[8*p +: 8] = m_oeb[p];
        end
        check("hreadyout", {63'd0, HREADYOUT}, 64'd1);
        check("gpio_out", gpio_out, eo);
        check("gpio_oeb", gpio_oeb, ee);
        check("user_irq", {48'd0, user_irq}, {48'd0, 8'h00, m_irq});
        if (m_ph_valid && !m_ph_write)
            check("hrdata", {32'd0, HRDATA}, {32'd0, m_read(m_ph_addr)});
    end

    // ---------------- bus tasks ----------------
    task automatic idle_bus();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    // Returns at the negedge inside the write data phase
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [2:0] sz);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = {24'd0, a}; HWRITE = 1'b1; HSIZE = sz;
        @(negedge HCLK);
        HWDATA = d;
        idle_bus();
        $display("[TB] write addr=0x%02h data=0x%08h size=%0d", a, d, sz);
    endtask

    // Returns the read data sampled inside the data phase
    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = {24'd0, a}; HWRITE = 1'b0; HSIZE = 3'b010;
        @(negedge HCLK);
        idle_bus();
        d = HRDATA;
        $display("[TB] read  addr=0x%02h data=0x%08h", a, d);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [31:0] rd;
        #1 HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        check("rst_hreadyout", {63'd0, HREADYOUT}, 64'd1);
        check("rst_oeb", gpio_oeb, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_out", gpio_out, 64'd0);
        check("rst_irq", {48'd0, user_irq}, 64'd0);
        check("rst_hrdata", {32'd0, HRDATA}, 64'd0);
        HRESETn = 1'b1;

        bus_read(8'h04, rd); check("rd_out0_rst", {32'd0, rd}, 64'h00);
        bus_read(8'h08, rd); check("rd_oeb0_rst", {32'd0, rd}, 64'hFF);

        // port3 OUT write and output latency
        bus_write(8'h34, 32'h0000_005A, 3'b010);
        @(negedge HCLK); check("out3_pending", {56'd0, gpio_out[31:24]}, 64'h00);
        @(negedge HCLK); check("out3_landed", {56'd0, gpio_out[31:24]}, 64'h5A);
        bus_read(8'h34, rd); check("rd_out3", {32'd0, rd}, 64'h5A);

        // back-to-back write then read of the same register
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h14; HWRITE = 1'b1; HSIZE = 3'b010;
        @(negedge HCLK);
        HWDATA = 32'h0000_00A5; HWRITE = 1'b0;
        @(negedge HCLK);
        idle_bus();
        rd = HRDATA;
        $display("[TB] b2b   addr=0x14 wdata=0xa5 rdata=0x%08h", rd);
        check("b2b_old", {32'd0, rd}, 64'h00);
        bus_read(8'h14, rd); check("b2b_new", {32'd0, rd}, 64'hA5);
        bus_write(8'h14, 32'h0000_00FF, 3'b000);
        bus_read(8'h14, rd); check("byte_write_dropped", {32'd0, rd}, 64'hA5);

        // port7 OEB
        bus_write(8'h78, 32'hFFFF_FF0F, 3'b010);
        bus_read(8'h78, rd); check("rd_oeb7", {32'd0, rd}, 64'h0F);

        // rising-edge interrupt on bit 0
        bus_write(8'h0C, 32'h1, 3'b010);
        repeat (3) @(negedge HCLK);
        gpio_in[0] = 1'b1;
        repeat (3) @(negedge HCLK); check("irq_not_yet", {63'd0, user_irq[0]}, 64'd0);
        @(negedge HCLK);            check("irq_raised", {63'd0, user_irq[0]}, 64'd1);
        bus_read(8'h80, rd); check("rd_stat0_set", {32'd0, rd}, 64'h01);
        bus_read(8'h00, rd); check("rd_in0", {32'd0, rd}, 64'h01);
        bus_write(8'h80, 32'h1, 3'b010);
        repeat (3) @(negedge HCLK); check("irq_cleared", {63'd0, user_irq[0]}, 64'd0);
        bus_read(8'h80, rd); check("rd_stat0_clr", {32'd0, rd}, 64'h00);

        // clearing IE keeps already-set status
        gpio_in[0] = 1'b0; repeat (4) @(negedge HCLK);
        gpio_in[0] = 1'b1; repeat (5) @(negedge HCLK);
        bus_write(8'h0C, 32'h0, 3'b010);
        bus_read(8'h80, rd); check("ie_off_keeps_stat", {32'd0, rd}, 64'h01);

        // W1C and new edge in the same cycle: set wins
        bus_write(8'h0C, 32'h1, 3'b010);
        gpio_in[0] = 1'b0; repeat (4) @(negedge HCLK);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h80; HWRITE = 1'b1; HSIZE = 3'b010;
        gpio_in[0] = 1'b1;
        @(negedge HCLK);
        HWDATA = 32'h1;
        idle_bus();
        repeat (3) @(negedge HCLK);
        bus_read(8'h80, rd); check("set_beats_clear", {32'd0, rd}, 64'h01);

        // async reset during a write data phase
        bus_write(8'h24, 32'h77, 3'b010);
        #2 HRESETn = 1'b0;
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);
        check("rst_mid_out2", {56'd0, gpio_out[23:16]}, 64'h00);
        check("rst_mid_irq", {48'd0, user_irq}, 64'd0);
        bus_read(8'h24, rd); check("rd_out2_after_rst", {32'd0, rd}, 64'h00);
        bus_read(8'h34, rd); check("rd_out3_after_rst", {32'd0, rd}, 64'h00);
        bus_read(8'hF0, rd); check("rd_unmapped", {32'd0, rd}, 64'h0);

        repeat (2) @(negedge HCLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
